rx_frame_parser: RTL and testbench
==================================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 The module SHALL have parameter HDR0, default 8'hAA, meaning the first header byte.
REQ-002 The module SHALL have parameter HDR1, default 8'h55, meaning the second header byte.
REQ-003 The module SHALL have parameter TIMEOUT_CYC, default 24'd2_400_000, meaning the inter-byte timeout in clk cycles.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port data_Byte, input, 8 bits: the received UART byte, valid only when Rx_done=1.
REQ-007 The module SHALL have port Rx_done, input, 1 bit: one-cycle strobe, one per received byte.
REQ-008 The module SHALL have port cmd, output, 8 bits: the command byte of the last good frame.
REQ-009 The module SHALL have ports rx_data1..rx_data9, output, 8 bits each: payload bytes D0..D8 of the last good frame.
REQ-010 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse when a good frame is accepted.
REQ-011 The module SHALL have port chk_err, output, 1 bit: one-cycle pulse when a frame is rejected on its checksum.
REQ-012 The module SHALL have port to_err, output, 1 bit: one-cycle pulse when a partial frame is aborted on timeout.

Function
REQ-013 The frame format SHALL be, in order: HDR0, HDR1, CMD, D0..D8, CHK, for 13 bytes in total.
REQ-014 CHK SHALL equal the sum CMD+D0+...+D8, modulo 256; header bytes are excluded.
REQ-015 The state machine SHALL have the states IDLE, WAIT_H1, GET_CMD, GET_DATA and GET_CHK, and SHALL advance only on cycles where Rx_done=1.
REQ-016 In IDLE, a byte equal to HDR0 SHALL move the state to WAIT_H1; any other byte SHALL keep the state in IDLE.
REQ-017 In WAIT_H1, the next state SHALL depend on the received byte:
- byte = HDR1: go to GET_CMD.
- byte = HDR0: stay in WAIT_H1.
- any other byte: go to IDLE.
REQ-018 In GET_CMD, the byte SHALL be stored in a shadow register, the running sum SHALL be initialised to that byte, the 4-bit data index SHALL be cleared to 0, and the state SHALL move to GET_DATA.
REQ-019 In GET_DATA, each byte SHALL be stored in shadow slot [index] and added to the running sum (8-bit wrap), and the index SHALL increment; after the byte with index 8, the state SHALL move to GET_CHK.
REQ-020 In GET_CHK, the byte SHALL be compared with the running sum, and the state SHALL return to IDLE in both outcomes:
- Match: the shadow registers are copied to cmd and rx_data1..9, and frame_done=1 on the next cycle.
- Mismatch: the outputs are unchanged, and chk_err=1 on the next cycle.
REQ-021 The latency SHALL be exactly 1 cycle: the outputs update and the pulse asserts on the cycle after the Rx_done that carries CHK.
REQ-022 cmd and rx_data1..9 SHALL hold their value until the next good frame; a partial or bad frame SHALL NOT alter them.
REQ-023 A 24-bit timeout counter SHALL clear on every Rx_done and while in IDLE, and SHALL otherwise increment.
REQ-024 When the timeout counter reaches TIMEOUT_CYC-1 outside IDLE, the state SHALL go to IDLE, and to_err SHALL pulse on the next cycle.
REQ-025 If Rx_done and timeout expiry occur in the same cycle, Rx_done SHALL win: the byte is processed, the counter is cleared, and there is no to_err.
REQ-026 A header byte arriving inside GET_CMD, GET_DATA or GET_CHK SHALL be treated as data; no resynchronisation occurs mid-frame.
REQ-027 frame_done, chk_err and to_err SHALL be mutually exclusive, and each SHALL be high for exactly one cycle per event.

Reset
REQ-028 When rst_n=0 at a rising clk edge, the module SHALL clear all of the following to 0:
- state to IDLE;
- index, running sum and timeout counter;
- shadow registers, cmd and rx_data1..9;
- frame_done, chk_err and to_err.
REQ-029 A reset applied mid-frame SHALL discard the partial frame with no error pulse; the first frame received after release SHALL be parsed normally.

Verification
REQ-030 Good frame: bytes AA 55 01 31 32 33 34 35 36 37 38 39 DE -> frame_done pulses once; cmd=01; rx_data1..9=31..39.
REQ-031 Bad checksum: the REQ-030 frame with CHK=DF -> chk_err pulses once; the outputs keep their previous values.
REQ-032 Header resync: AA AA 55 followed by the REQ-030 tail -> frame_done pulses; the outputs match REQ-030.
REQ-033 Timeout: AA 55 01 31, then idle for TIMEOUT_CYC cycles -> to_err pulses once; then a full good frame -> frame_done pulses.
REQ-034 Reset mid-frame: rst_n=0 for 1 cycle after byte 6 of a frame -> the outputs are 0 and no pulse occurs; the next full frame is accepted.
REQ-035 Wrap/collision: payload of all FF with CMD=FF -> CHK=F6 is accepted; Rx_done coincident with timeout expiry -> no to_err.

Source files
------------

// File: rtl/rx_frame_parser.sv
// UART frame parser: AA 55 CMD D0..D8 CHK with additive checksum.
// Partial frames abort on an inter-byte timeout.
module rx_frame_parser #(
  parameter logic [7:0]  HDR0        = 8'hAA,
  parameter logic [7:0]  HDR1        = 8'h55,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2_400_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_Byte,
  input  logic       Rx_done,
  output logic [7:0] cmd,
  output logic [7:0] rx_data1,
  output logic [7:0] rx_data2,
  output logic [7:0] rx_data3,
  output logic [7:0] rx_data4,
  output logic [7:0] rx_data5,
  output logic [7:0] rx_data6,
  output logic [7:0] rx_data7,
  output logic [7:0] rx_data8,
  output logic [7:0] rx_data9,
  output logic       frame_done,
  output logic       chk_err,
  output logic       to_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_H1,
    GET_CMD,
    GET_DATA,
    GET_CHK
  } state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_sum;
  logic [23:0] r_to_cnt;
  logic [7:0]  r_sh_cmd;
  logic [7:0]  r_sh [9];

  logic w_expired;
  assign w_expired = (r_state != IDLE) &&
                     (r_to_cnt == TIMEOUT_CYC - 24'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_sum      <= '0;
      r_to_cnt   <= '0;
      r_sh_cmd   <= '0;
      for (int i = 0; i < 9; i++) r_sh[i] <= '0;
      cmd        <= '0;
      rx_data1   <= '0;
      rx_data2   <= '0;
      rx_data3   <= '0;
      rx_data4   <= '0;
      rx_data5   <= '0;
      rx_data6   <= '0;
      rx_data7   <= '0;
      rx_data8   <= '0;
      rx_data9   <= '0;
      frame_done <= 1'b0;
      chk_err    <= 1'b0;
      to_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      chk_err    <= 1'b0;
      to_err     <= 1'b0;

      if (Rx_done || r_state == IDLE) r_to_cnt <= '0;
      else                            r_to_cnt <= r_to_cnt + 24'd1;

      // A byte arriving on the expiry cycle beats the timeout
      if (Rx_done) begin
        unique case (r_state)
          IDLE: begin
            if (data_Byte == HDR0) r_state <= WAIT_H1;
          end
          WAIT_H1: begin
            if (data_Byte == HDR1)      r_state <= GET_CMD;
            else if (data_Byte == HDR0) r_state <= WAIT_H1;
            else                        r_state <= IDLE;
          end
          GET_CMD: begin
            r_sh_cmd <= data_Byte;
            r_sum    <= data_Byte;
            r_idx    <= '0;
            r_state  <= GET_DATA;
          end
          GET_DATA: begin
            r_sh[r_idx] <= data_Byte;
            r_sum       <= r_sum + data_Byte;
            r_idx       <= r_idx + 4'd1;
            if (r_idx == 4'd8) r_state <= GET_CHK;
          end
          GET_CHK: begin
            if (data_Byte == r_sum) begin
              cmd        <= r_sh_cmd;
              rx_data1   <= r_sh[0];
              rx_data2   <= r_sh[1];
              rx_data3   <= r_sh[2];
              rx_data4   <= r_sh[3];
              rx_data5   <= r_sh[4];
              rx_data6   <= r_sh[5];
              rx_data7   <= r_sh[6];
              rx_data8   <= r_sh[7];
              rx_data9   <= r_sh[8];
              frame_done <= 1'b1;
            end else begin
              chk_err <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_expired) begin
        r_state <= IDLE;
        to_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser with a short timeout.
// Pulses are counted per cycle alongside inline checks.
module tb_rx_frame_parser;

  localparam int T = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_Byte;
  logic       Rx_done;
  logic [7:0] cmd;
  logic [7:0] rx_data1, rx_data2, rx_data3;
  logic [7:0] rx_data4, rx_data5, rx_data6;
  logic [7:0] rx_data7, rx_data8, rx_data9;
  logic       frame_done, chk_err, to_err;

  rx_frame_parser #(
    .HDR0(8'hAA),
    .HDR1(8'h55),
    .TIMEOUT_CYC(24'd40)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_Byte(data_Byte),
    .Rx_done(Rx_done),
    .cmd(cmd),
    .rx_data1(rx_data1),
    .rx_data2(rx_data2),
    .rx_data3(rx_data3),
    .rx_data4(rx_data4),
    .rx_data5(rx_data5),
    .rx_data6(rx_data6),
    .rx_data7(rx_data7),
    .rx_data8(rx_data8),
    .rx_data9(rx_data9),
    .frame_done(frame_done),
    .chk_err(chk_err),
    .to_err(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_fd = 0;
  int n_ce = 0;
  int n_to = 0;

  logic [79:0] outs;
  logic [2:0]  pulses;
  assign outs = {cmd, rx_data1, rx_data2, rx_data3, rx_data4,
                 rx_data5, rx_data6, rx_data7, rx_data8, rx_data9};
  assign pulses = {frame_done, chk_err, to_err};

  localparam logic [71:0] P_GOOD = 72'h31_32_33_34_35_36_37_38_39;
  localparam logic [71:0] P_ALT  = 72'h41_42_43_44_45_46_47_48_49;
  localparam logic [71:0] P_HDR  = 72'h55_AA_55_AA_00_00_00_00_01;
  localparam logic [71:0] P_FF   = 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_done === 1'b1) n_fd++;
      if (chk_err === 1'b1)    n_ce++;
      if (to_err === 1'b1)     n_to++;
      if (pulses !== 3'b000) begin
        checks++;
        if (pulses !== 3'b100 && pulses !== 3'b010 &&
            pulses !== 3'b001) begin
          errors++;
          $display("FAIL exclusive pulses got %b need one-hot", pulses);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int idle);
    data_Byte = b;
    Rx_done   = 1'b1;
    @(negedge clk);
    Rx_done   = 1'b0;
    data_Byte = 8'h00;
    repeat (idle) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [71:0] p,
                            input logic [7:0] k, input int idle);
    send_byte(8'hAA, idle);
    send_byte(8'h55, idle);
    send_byte(c, idle);
    for (int i = 0; i < 9; i++) send_byte(p[71-8*i -: 8], idle);
    send_byte(k, 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    Rx_done = 1'b0;
    data_Byte = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 80'h0) begin
      errors++;
      $display("FAIL reset_outs got %h need 0", outs);
    end
    checks++;
    if (pulses !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses got %b need 000", pulses);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 80'h0 || pulses !== 3'b000) begin
      errors++;
      $display("FAIL post_reset got %h/%b need 0/000", outs, pulses);
    end
  endtask

  task automatic test_good_frame;
    int fd0;
    fd0 = n_fd;
    send_frame(8'h01, P_GOOD, 8'hDE, 0);
    checks++;
    if (pulses !== 3'b100) begin
      errors++;
      $display("FAIL good_pulse got %b need 100", pulses);
    end
    checks++;
    if (outs !== {8'h01, P_GOOD}) begin
      errors++;
      $display("FAIL good_outs got %h need %h", outs, {8'h01, P_GOOD});
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL good_one_cycle got %b need 0", frame_done);
    end
    checks++;
    if (n_fd - fd0 !== 1) begin
      errors++;
      $display("FAIL good_count got %0d need 1", n_fd - fd0);
    end
  endtask

  task automatic test_bad_chk;
    int ce0;
    ce0 = n_ce;
    send_frame(8'h02, P_ALT, 8'h70, 0);
    checks++;
    if (pulses !== 3'b010) begin
      errors++;
      $display("FAIL badchk_pulse got %b need 010", pulses);
    end
    checks++;
    if (outs !== {8'h01, P_GOOD}) begin
      errors++;
      $display("FAIL badchk_hold got %h need %h", outs, {8'h01, P_GOOD});
    end
    send_frame(8'h01, P_GOOD, 8'hDF, 0);
    @(negedge clk);
    checks++;
    if (n_ce - ce0 !== 2) begin
      errors++;
      $display("FAIL badchk_count got %0d need 2", n_ce - ce0);
    end
  endtask

  task automatic test_update;
    send_frame(8'h02, P_ALT, 8'h6F, 0);
    checks++;
    if (pulses !== 3'b100 || outs !== {8'h02, P_ALT}) begin
      errors++;
      $display("FAIL update got %b/%h need 100/%h",
               pulses, outs, {8'h02, P_ALT});
    end
    @(negedge clk);
  endtask

  task automatic test_header_resync;
    send_byte(8'hAA, 0);
    send_frame(8'h01, P_GOOD, 8'hDE, 0);
    checks++;
    if (pulses !== 3'b100 || outs !== {8'h01, P_GOOD}) begin
      errors++;
      $display("FAIL resync got %b/%h need 100/%h",
               pulses, outs, {8'h01, P_GOOD});
    end
    @(negedge clk);
  endtask

  task automatic test_header_in_data;
    send_frame(8'hAA, P_HDR, 8'hA9, 0);
    checks++;
    if (pulses !== 3'b100 || outs !== {8'hAA, P_HDR}) begin
      errors++;
      $display("FAIL hdr_in_data got %b/%h need 100/%h",
               pulses, outs, {8'hAA, P_HDR});
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int to0, fd0;
    to0 = n_to;
    fd0 = n_fd;
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    send_byte(8'h01, 0);
    send_byte(8'h31, 0);
    repeat (T - 1) @(negedge clk);
    checks++;
    if (to_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %b need 0", to_err);
    end
    @(negedge clk);
    checks++;
    if (pulses !== 3'b001) begin
      errors++;
      $display("FAIL timeout_pulse got %b need 001", pulses);
    end
    @(negedge clk);
    checks++;
    if (to_err !== 1'b0 || outs !== {8'hAA, P_HDR}) begin
      errors++;
      $display("FAIL timeout_after got %b/%h need 0/%h",
               to_err, outs, {8'hAA, P_HDR});
    end
    repeat (T + 3) @(negedge clk);
    send_frame(8'h01, P_GOOD, 8'hDE, 0);
    @(negedge clk);
    checks++;
    if (n_to - to0 !== 1 || n_fd - fd0 !== 1) begin
      errors++;
      $display("FAIL timeout_counts got to=%0d fd=%0d need 1/1",
               n_to - to0, n_fd - fd0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int fd0, ce0, to0;
    fd0 = n_fd;
    ce0 = n_ce;
    to0 = n_to;
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    send_byte(8'h01, 0);
    send_byte(8'h31, 0);
    send_byte(8'h32, 0);
    send_byte(8'h33, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (outs !== 80'h0 || pulses !== 3'b000) begin
      errors++;
      $display("FAIL midreset got %h/%b need 0/000", outs, pulses);
    end
    repeat (T + 5) @(negedge clk);
    checks++;
    if (n_fd != fd0 || n_ce != ce0 || n_to != to0) begin
      errors++;
      $display("FAIL midreset_quiet got fd=%0d ce=%0d to=%0d need 0",
               n_fd - fd0, n_ce - ce0, n_to - to0);
    end
    send_frame(8'h02, P_ALT, 8'h6F, 0);
    checks++;
    if (pulses !== 3'b100 || outs !== {8'h02, P_ALT}) begin
      errors++;
      $display("FAIL midreset_next got %b/%h need 100/%h",
               pulses, outs, {8'h02, P_ALT});
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    send_frame(8'hFF, P_FF, 8'hF6, 0);
    checks++;
    if (pulses !== 3'b100 || outs !== {8'hFF, P_FF}) begin
      errors++;
      $display("FAIL wrap got %b/%h need 100/%h",
               pulses, outs, {8'hFF, P_FF});
    end
    @(negedge clk);
  endtask

  task automatic test_collision;
    int fd0, to0;
    fd0 = n_fd;
    to0 = n_to;
    send_frame(8'h01, P_GOOD, 8'hDE, T - 1);
    checks++;
    if (pulses !== 3'b100 || outs !== {8'h01, P_GOOD}) begin
      errors++;
      $display("FAIL collision got %b/%h need 100/%h",
               pulses, outs, {8'h01, P_GOOD});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_to != to0 || n_fd - fd0 !== 1) begin
      errors++;
      $display("FAIL collision_counts got to=%0d fd=%0d need 0/1",
               n_to - to0, n_fd - fd0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_update();
    test_header_resync();
    test_header_in_data();
    test_timeout();
    test_reset_mid_frame();
    test_wrap();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
